seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for each processor core; successor to the single-cycle combinational ALU.
//  Add/sub/logic complete in 1 cycle. Multiply is iterative shift-add; divide/mod is iterative restoring division.
//  A start/busy/done handshake lets the core's control unit stall while a long op runs.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  CNT_W  $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only in IDLE
//  A_bus    in   WIDTH  operand A, unsigned; captured on accepted start
//  B_bus    in   WIDTH  operand B, unsigned; captured on accepted start
//  op       in   3      000 passA, 001 add, 010 sub, 011 mul, 100 div, 101 mod, 110 and, 111 or
//  C_bus    out  WIDTH  result register
//  Z        out  1      1 when the committed C_bus == 0
//  dz       out  1      divide-by-zero flag for op 100/101 with B==0
//  busy     out  1      high from accept until done, inclusive
//  done     out  1      one-cycle pulse: C_bus/Z/dz valid and updated this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; C_bus=0, Z=0, dz=0, busy=0, done=0; counter and shadow regs cleared.
//  FSM states: IDLE, MUL, DIV, FIN.
//   IDLE: start=1 at an edge -> capture A, B, op; busy=1 next cycle. passA/add/sub/and/or, or div/mod with B==0 -> FIN.
//         mul -> MUL; div/mod with B!=0 -> DIV.
//   MUL: WIDTH iterations, one multiplier bit per cycle (LSB first); accumulate WIDTH-bit product (mod 2^WIDTH) -> FIN.
//   DIV: WIDTH iterations restoring division, MSB first; quotient and remainder both WIDTH bits -> FIN.
//   FIN: commit C_bus, Z, dz; done=1, busy=1 for this cycle; -> IDLE.
//  Latency, counted in edges from the accept edge to done high: 1 for simple ops and div-by-zero; WIDTH+1 for mul/div/mod.
//  Back-to-back: start may be high again in the cycle after done. The ALU returns to IDLE at the done edge,
//   so an op issued then is accepted at that same edge.
//  Arithmetic: add/sub wrap modulo 2^WIDTH with no carry output. Example: 6-7 = all ones.
//   mul keeps the low WIDTH bits. div gives floor(A/B); mod gives A - B*floor(A/B).
//  Divide by zero: div -> C_bus = all ones; mod -> C_bus = A. dz=1 with the done pulse.
//   dz=0 for every other committed op. Z follows C_bus in all cases.
//  start while busy: ignored, no queuing. Operand or op changes after accept have no effect.
//  Outputs hold their last committed values until the next FIN, and are not disturbed mid-operation.
//  Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//  op is decoded only at accept; all 8 codes are legal.
// CONFIGURATION
//  ALU_FAST_MUL_EN defined: mul is a single-cycle combinational WIDTH x WIDTH multiply (low WIDTH bits).
//   Mul goes IDLE -> FIN, latency 1; the MUL state is not built.
//  ALU_FAST_MUL_EN undefined: iterative multiply, latency WIDTH+1 as above. Results are identical in both modes.
// TESTING  (WIDTH=32 unless noted)
//  1. Async reset: rst_n low between edges -> all outputs 0 at once. Simple ops: A=10, B=6, op=001 -> C_bus=16,
//     Z=0, done 1 edge after accept. A=B=7, op=010 -> C_bus=0, Z=1. A=6, B=7, op=010 -> C_bus=32'hFFFFFFFF, Z=0.
//  2. mul: A=8, B=7, op=011 -> C_bus=56, done exactly 33 edges after accept, busy high throughout.
//     A=B=32'h10000 -> C_bus=0, Z=1.
//  3. div/mod: A=17, B=5 -> op=100 gives C_bus=3; op=101 gives C_bus=2. Each done 33 edges after accept, dz=0.
//  4. Divide by zero: A=17, B=0 -> op=100 gives C_bus=32'hFFFFFFFF, dz=1; op=101 gives C_bus=17, dz=1.
//     Each done 1 edge after accept.
//  5. Handshake: pulse start during an active mul with op=001 -> ignored, mul result 56 unchanged. Start asserted
//     in the done cycle -> next op accepted at once. rst_n pulsed mid-div -> no done, C_bus=0, next op correct.
//  6. ALU_FAST_MUL_EN defined: A=8, B=7, op=011 -> C_bus=56, done 1 edge after accept. Random regression with
//     WIDTH=8 and WIDTH=32 vs a behavioural model in both macro settings.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake.
// Add/sub/logic/passA take one cycle. Multiply is shift-add over WIDTH cycles.
// Divide and modulo use restoring division over WIDTH cycles.
// Optional feature macro: ALU_FAST_MUL_EN selects a single-cycle combinational
// multiply and leaves out the MUL state.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] C_bus,
  output logic             Z,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MOD   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_OR    = 3'b111;

`ifdef ALU_FAST_MUL_EN
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
`endif

  state_t state, state_nx;

  // Shadow registers. a_reg doubles as multiplicand (shifted left) during MUL
  // and as dividend/quotient (shifted left) during DIV; acc holds the product
  // during MUL and the partial remainder during DIV.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             cnt_last;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] res;
  logic             res_dz;

`ifdef ALU_FAST_MUL_EN
  logic [WIDTH-1:0] fast_prod;
  assign fast_prod = a_reg * b_reg;
`endif

  assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

  // Restoring division step: shift next dividend bit into the remainder and
  // trial-subtract the divisor; bit WIDTH of the difference is the borrow.
  assign rem_sh   = {acc, a_reg[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_reg};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; op is only examined at accept.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
`ifdef ALU_FAST_MUL_EN
            OP_MUL:         state_nx = FIN;
`else
            OP_MUL:         state_nx = MUL;
`endif
            OP_DIV, OP_MOD: state_nx = (B_bus == '0) ? FIN : DIV;
            default:        state_nx = FIN;
          endcase
        end
      end
`ifndef ALU_FAST_MUL_EN
      MUL:     state_nx = cnt_last ? FIN : MUL;
`endif
      DIV:     state_nx = cnt_last ? FIN : DIV;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result selection from the shadow registers, used when committing in FIN.
  always_comb begin
    res    = '0;
    res_dz = 1'b0;
    case (op_reg)
      OP_PASSA: res = a_reg;
      OP_ADD:   res = a_reg + b_reg;
      OP_SUB:   res = a_reg - b_reg;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:   res = fast_prod;
`else
      OP_MUL:   res = acc;
`endif
      OP_DIV: begin
        if (b_reg == '0) begin
          res    = '1;
          res_dz = 1'b1;
        end else begin
          res = a_reg;
        end
      end
      OP_MOD: begin
        if (b_reg == '0) begin
          res    = a_reg;
          res_dz = 1'b1;
        end else begin
          res = acc;
        end
      end
      OP_AND:   res = a_reg & b_reg;
      OP_OR:    res = a_reg | b_reg;
      default:  res = '0;
    endcase
  end

  // Datapath, iteration counter and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      acc    <= '0;
      cnt    <= '0;
      C_bus  <= '0;
      Z      <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high through the done cycle and only drops here
          busy <= start;
          if (start) begin
            a_reg  <= A_bus;
            b_reg  <= B_bus;
            op_reg <= op;
            acc    <= '0;
            cnt    <= '0;
          end
        end
`ifndef ALU_FAST_MUL_EN
        MUL: begin
          acc   <= acc + (b_reg[0] ? a_reg : '0);
          a_reg <= {a_reg[WIDTH-2:0], 1'b0};
          b_reg <= {1'b0, b_reg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
`endif
        DIV: begin
          if (!rem_diff[WIDTH]) begin
            acc   <= rem_diff[WIDTH-1:0];
            a_reg <= {a_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc   <= rem_sh[WIDTH-1:0];
            a_reg <= {a_reg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          C_bus <= res;
          Z     <= (res == '0);
          dz    <= res_dz;
          done  <= 1'b1;
          busy  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an
// arithmetic reference model. Honors ALU_FAST_MUL_EN for expected latency.
module tb_seq_alu;
  parameter int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A_bus = '0;
  logic [W-1:0] B_bus = '0;
  logic [2:0]   op = '0;
  logic [W-1:0] C_bus;
  logic         Z, dz, busy, done;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] last_c = '0;
  logic         last_z = 1'b0;
  logic         last_dz = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A_bus(A_bus), .B_bus(B_bus),
    .op(op), .C_bus(C_bus), .Z(Z), .dz(dz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference result: {dz, value}, straight from the arithmetic definitions.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] o);
    logic [W-1:0] r;
    logic         d;
    r = '0;
    d = 1'b0;
    case (o)
      3'd0: r = a;
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a * b;
      3'd4: if (b == '0) begin r = '1; d = 1'b1; end else r = a / b;
      3'd5: if (b == '0) begin r = a;  d = 1'b1; end else r = a % b;
      3'd6: r = a & b;
      default: r = a | b;
    endcase
    return {d, r};
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic [2:0] o);
`ifdef ALU_FAST_MUL_EN
    if (o == 3'd3) return 1;
`else
    if (o == 3'd3) return W + 1;
`endif
    if ((o == 3'd4 || o == 3'd5) && b != '0) return W + 1;
    return 1;
  endfunction

  task automatic check_v(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_i(input string tag, input int got, input int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for done, check everything.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input string tag, input bit poke);
    logic [W:0]   exp;
    logic [W-1:0] exp_c;
    int           lat;
    int           edges;
    bit           hold_ok;
    exp     = model(a, b, o);
    exp_c   = exp[W-1:0];
    lat     = model_lat(b, o);
    hold_ok = 1'b1;
    @(negedge clk);
    A_bus = a; B_bus = b; op = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A_bus = W'($urandom); B_bus = W'($urandom); op = 3'($urandom);
    edges = 0;
    while (!done && edges < 2 * W + 8) begin
      if (C_bus !== last_c || Z !== last_z || dz !== last_dz || busy !== 1'b1) hold_ok = 1'b0;
      if (poke) begin
        start = (edges >= 1 && edges <= 4);
        op    = 3'b001;
        A_bus = W'($urandom);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    check_i({tag, ".done"}, int'(done), 1);
    check_i({tag, ".latency"}, edges, lat);
    check_v({tag, ".C"}, C_bus, exp_c);
    check_i({tag, ".Z"}, int'(Z), int'(exp_c == '0));
    check_i({tag, ".dz"}, int'(dz), int'(exp[W]));
    check_i({tag, ".busy_at_done"}, int'(busy), 1);
    check_i({tag, ".hold_busy"}, int'(hold_ok), 1);
    last_c  = exp_c;
    last_z  = (exp_c == '0);
    last_dz = exp[W];
  endtask

  // Idle cycles after an op: done must be a single pulse and busy must fall.
  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_i({tag, ".done_low"}, int'(done), 0);
      check_i({tag, ".busy_low"}, int'(busy), 0);
      check_v({tag, ".C_hold"}, C_bus, last_c);
    end
  endtask

  logic [W-1:0] ra, rb, half;
  logic [2:0]   ro;
  bit           no_done;

  initial begin
    // Reset held: all outputs zero.
    #1;
    check_v("rst.C", C_bus, '0);
    check_i("rst.Z", int'(Z), 0);
    check_i("rst.dz", int'(dz), 0);
    check_i("rst.busy", int'(busy), 0);
    check_i("rst.done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(W'(10), W'(6), 3'b001, "add", 1'b0);

    // Asynchronous reset between edges while done/C_bus are set.
    #2;
    rst_n = 1'b0;
    #1;
    check_v("arst.C", C_bus, '0);
    check_i("arst.done", int'(done), 0);
    check_i("arst.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_c = '0; last_z = 1'b0; last_dz = 1'b0;

    run_op(W'(7), W'(7), 3'b010, "sub_eq", 1'b0);
    run_op(W'(6), W'(7), 3'b010, "sub_wrap", 1'b0);
    idle_check(2, "gap1");
    run_op(W'(8), W'(7), 3'b011, "mul", 1'b0);
    half = W'(1) << (W / 2);
    run_op(half, half, 3'b011, "mul_ovf", 1'b0);
    run_op(W'(8), W'(7), 3'b011, "mul_poke", 1'b1);
    run_op(W'(17), W'(5), 3'b100, "div", 1'b0);
    run_op(W'(17), W'(5), 3'b101, "mod", 1'b0);
    run_op(W'(17), W'(0), 3'b100, "div0", 1'b0);
    run_op(W'(17), W'(0), 3'b101, "mod0", 1'b0);
    run_op(W'(9), W'(3), 3'b000, "passa", 1'b0);
    run_op(W'(12), W'(10), 3'b110, "and", 1'b0);
    run_op(W'(12), W'(3), 3'b111, "or", 1'b0);
    run_op(W'(8), W'(7), 3'b011, "mul_pre_rst", 1'b0);

    // Reset pulse mid-divide: abort, no done, outputs cleared.
    @(negedge clk);
    A_bus = W'(17); B_bus = W'(5); op = 3'b100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_v("mid_rst.C", C_bus, '0);
    check_i("mid_rst.busy", int'(busy), 0);
    check_i("mid_rst.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_c = '0; last_z = 1'b0; last_dz = 1'b0;
    no_done = 1'b1;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (done || busy) no_done = 1'b0;
    end
    check_i("mid_rst.no_done", int'(no_done), 1);
    run_op(W'(17), W'(5), 3'b101, "post_rst_mod", 1'b0);

    // Randomized regression, mixing back-to-back issue and idle gaps.
    for (int n = 0; n < 250; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 255));
      ro = 3'($urandom);
      run_op(ra, rb, ro, "rand", 1'b0);
      if ($urandom_range(0, 4) == 0) idle_check(1, "rand_gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
